// File: rtl/mul_seq16.sv
// Sequential 16x16 unsigned shift-add multiplier that borrows an external
// 16-bit adder; one partial-product step per clock, 16 steps per product.
//
// state  | meaning
// IDLE   | waiting for start; adder operands forced to zero
// RUN    | 16 shift-add steps, busy high
// DONE   | one-cycle done pulse, product valid in p
module mul_seq16 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] add_a,
    output logic [15:0] add_b,
    output logic        add_ci,
    input  logic [15:0] add_r,
    input  logic        add_co,
    output logic        busy,
    output logic        done,
    output logic [31:0] p
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] m_q, m_d;
    logic [15:0] h_q, h_d;
    logic [15:0] l_q, l_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] p_q, p_d;
    logic [31:0] step_sum;

    // Carry, sum and the surviving multiplier bits shifted right as one word.
    assign step_sum = {add_co, add_r, l_q[15:1]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            m_q     <= 16'h0000;
            h_q     <= 16'h0000;
            l_q     <= 16'h0000;
            cnt_q   <= 4'd0;
            p_q     <= 32'h0000_0000;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            h_q     <= h_d;
            l_q     <= l_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
        end
    end

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        h_d     = h_q;
        l_d     = l_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        add_a   = 16'h0000;
        add_b   = 16'h0000;
        add_ci  = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    m_d     = a;
                    h_d     = 16'h0000;
                    l_d     = b;
                    cnt_d   = 4'd0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                busy       = 1'b1;
                add_a      = h_q;
                add_b      = l_q[0] ? m_q : 16'h0000;
                {h_d, l_d} = step_sum;
                cnt_d      = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    p_d     = step_sum;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign p = p_q;

endmodule
